axis_rr_packet_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one AXI-stream output register stage among NUM upstream AXI-stream sources.
- A source, once granted, holds the output until the beat carrying tlast is accepted.
- The output is a registered pipe stage: tdata, tvalid, tlast, tkeep and tuser are flopped; the ready path is derived combinationally from the output state.
- Placed ahead of shared sinks: DMA write channel, MAC TX, packet FIFO.

---
 rtl/axis_rr_packet_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rr_packet_arbiter
//  Purpose  : Packet-level round-robin arbiter in front of one registered
//             AXI-stream output stage. Optional stall watchdog is enabled by
//             defining AXIS_RR_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module axis_rr_packet_arbiter #(
   parameter int NUM     = 4,
   parameter int DSIZE   = 32,
   parameter int KSIZE   = DSIZE/8,
   parameter int USIZE   = 1,
   parameter int TIMEOUT = 256
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic [NUM*DSIZE-1:0]   in_tdata,
   input  logic [NUM-1:0]         in_tvalid,
   input  logic [NUM-1:0]         in_tlast,
   input  logic [NUM*KSIZE-1:0]   in_tkeep,
   input  logic [NUM*USIZE-1:0]   in_tuser,
   output logic [NUM-1:0]         in_tready,
   output logic [DSIZE-1:0]       out_tdata,
   output logic                   out_tvalid,
   output logic                   out_tlast,
   output logic [KSIZE-1:0]       out_tkeep,
   output logic [USIZE-1:0]       out_tuser,
   input  logic                   out_tready,
   output logic [$clog2(NUM)-1:0] grant_id,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int IW = $clog2(NUM);

   if (NUM < 2 || NUM > 16 || TIMEOUT < 2) begin : g_param_check
      $error("axis_rr_packet_arbiter: NUM must be 2..16 and TIMEOUT >= 2");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [IW-1:0]     r_grant, w_grant_nxt;
   logic [IW-1:0]     r_last,  w_last_nxt;
   logic [IW-1:0]     w_sel;
   logic              w_found;
   logic              w_en;
   logic              w_acc;
   logic              w_fire;
   logic [NUM-1:0]    w_tready;

   logic [DSIZE-1:0]  r_out_tdata;
   logic              r_out_tvalid;
   logic              r_out_tlast;
   logic [KSIZE-1:0]  r_out_tkeep;
   logic [USIZE-1:0]  r_out_tuser;

   assign w_en  = ~r_out_tvalid | out_tready;
   assign w_acc = (r_state == ST_LOCK) & in_tvalid[r_grant] & w_en;

   // Rotating scan: first requester strictly after the last packet owner.
   always_comb begin
      w_sel   = r_last;
      w_found = 1'b0;
      for (int k = 1; k <= NUM; k++) begin
         logic [IW-1:0] w_idx;
         w_idx = IW'((int'(r_last) + k) % NUM);
         if (!w_found && in_tvalid[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_tready = '0;
      if (r_state == ST_LOCK && w_en) begin
         w_tready[r_grant] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= IW'(NUM - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         ST_IDLE: begin
            if (|in_tvalid) begin
               w_state_nxt = ST_LOCK;
               w_grant_nxt = w_sel;
            end
         end
         ST_LOCK: begin
            if ((w_acc && in_tlast[r_grant]) || w_fire) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_grant;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A new beat takes priority over retiring the old one: 1 beat/cycle.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out_tdata  <= '0;
         r_out_tvalid <= 1'b0;
         r_out_tlast  <= 1'b0;
         r_out_tkeep  <= '1;
         r_out_tuser  <= '0;
      end else if (w_acc) begin
         r_out_tdata  <= in_tdata[int'(r_grant)*DSIZE +: DSIZE];
         r_out_tvalid <= 1'b1;
         r_out_tlast  <= in_tlast[r_grant];
         r_out_tkeep  <= in_tkeep[int'(r_grant)*KSIZE +: KSIZE];
         r_out_tuser  <= in_tuser[int'(r_grant)*USIZE +: USIZE];
      end else if (r_out_tvalid && out_tready) begin
         r_out_tdata  <= '0;
         r_out_tvalid <= 1'b0;
         r_out_tlast  <= 1'b0;
         r_out_tkeep  <= '1;
         r_out_tuser  <= '0;
      end
   end

`ifdef AXIS_RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_stall;
   logic          r_tout;
   logic          w_stall;

   assign w_stall = (r_state == ST_LOCK) & ~in_tvalid[r_grant];
   assign w_fire  = w_stall & (r_stall == CW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
         r_tout  <= 1'b0;
      end else begin
         r_tout <= w_fire;
         if (w_acc || w_fire || (r_state != ST_LOCK)) begin
            r_stall <= '0;
         end else if (w_stall) begin
            r_stall <= r_stall + CW'(1);
         end
      end
   end

   assign timeout_err = r_tout;
`else
   assign w_fire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign in_tready  = w_tready;
   assign out_tdata  = r_out_tdata;
   assign out_tvalid = r_out_tvalid;
   assign out_tlast  = r_out_tlast;
   assign out_tkeep  = r_out_tkeep;
   assign out_tuser  = r_out_tuser;
   assign grant_id   = r_grant;
   assign busy       = (r_state == ST_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_rr_packet_arbiter
//  Purpose  : Directed self-checking bench for axis_rr_packet_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_rr_packet_arbiter;

   localparam int NUM     = 4;
   localparam int DSIZE   = 32;
   localparam int KSIZE   = 4;
   localparam int USIZE   = 1;
   localparam int TIMEOUT = 8;

   logic                 clock;
   logic                 rst_n;
   logic [NUM*DSIZE-1:0] in_tdata;
   logic [NUM-1:0]       in_tvalid;
   logic [NUM-1:0]       in_tlast;
   logic [NUM*KSIZE-1:0] in_tkeep;
   logic [NUM*USIZE-1:0] in_tuser;
   logic [NUM-1:0]       in_tready;
   logic [DSIZE-1:0]     out_tdata;
   logic                 out_tvalid;
   logic                 out_tlast;
   logic [KSIZE-1:0]     out_tkeep;
   logic [USIZE-1:0]     out_tuser;
   logic                 out_tready;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 timeout_err;

   axis_rr_packet_arbiter #(
      .NUM(NUM), .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .clock(clock), .rst_n(rst_n),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
      .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
      .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tready(out_tready),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0]    srcq [NUM][$];   // {tlast, tdata} per source
   logic [39:0]    outq [$];        // {grant, 3'b0, tlast, tdata} per transfer
   logic [39:0]    expq [$];
   logic [NUM-1:0] hold;
   logic [NUM-1:0] hs;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] bdata(int src, int pkt, int b);
      return 32'hC0DE_0000 | 32'(src << 8) | 32'(pkt << 4) | 32'(b);
   endfunction

   function automatic logic [32:0] beat(int src, int pkt, int b, bit last);
      return {last, bdata(src, pkt, b)};
   endfunction

   function automatic logic [39:0] xfer(int src, int pkt, int b, bit last);
      return {4'(src), 3'b000, last, bdata(src, pkt, b)};
   endfunction

   // Sources present their queue head; keep/user are fixed per source.
   task automatic drive();
      for (int i = 0; i < NUM; i++) begin
         if (srcq[i].size() > 0 && !hold[i]) begin
            in_tvalid[i]               = 1'b1;
            in_tdata[i*DSIZE +: DSIZE] = srcq[i][0][31:0];
            in_tlast[i]                = srcq[i][0][32];
         end else begin
            in_tvalid[i]               = 1'b0;
            in_tdata[i*DSIZE +: DSIZE] = '0;
            in_tlast[i]                = 1'b0;
         end
         in_tkeep[i*KSIZE +: KSIZE] = 4'(i + 1);
         in_tuser[i]                = ((i % 2) == 0);
      end
   endtask

   // One clock: record handshakes just before the edge, then advance sources.
   task automatic step();
      #1;
      hs = in_tvalid & in_tready;
      if (out_tvalid && out_tready)
         outq.push_back({4'(grant_id), 3'b000, out_tlast, out_tdata});
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM; i++)
         if (hs[i]) void'(srcq[i].pop_front());
      drive();
      @(negedge clock);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      hold       = '0;
      out_tready = 1'b1;
      for (int i = 0; i < NUM; i++) srcq[i].delete();
      drive();
      outq.delete();
      expq.delete();
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int cyc = 0;
      while (outq.size() < n && cyc < budget) begin
         step();
         cyc++;
      end
      check_eq({tag, "_count"}, 64'(outq.size()), 64'(n));
      for (int j = 0; j < expq.size(); j++)
         check_eq($sformatf("%s_x%0d", tag, j),
                  (j < outq.size()) ? 64'(outq[j]) : 64'hDEAD, 64'(expq[j]));
   endtask

   initial begin
      rst_n      = 1'b0;
      hold       = '0;
      out_tready = 1'b1;
      drive();
      repeat (2) @(negedge clock);
      check_eq("rst_tvalid", 64'(out_tvalid), 64'h0);
      check_eq("rst_tdata",  64'(out_tdata),  64'h0);
      check_eq("rst_tlast",  64'(out_tlast),  64'h0);
      check_eq("rst_tkeep",  64'(out_tkeep),  64'hF);
      check_eq("rst_tuser",  64'(out_tuser),  64'h0);
      check_eq("rst_grant",  64'(grant_id),   64'h0);
      check_eq("rst_busy",   64'(busy),       64'h0);
      check_eq("rst_tout",   64'(timeout_err), 64'h0);
      check_eq("rst_tready", 64'(in_tready),  64'h0);
      rst_n = 1'b1;

      // Single source, 3-beat packet: bubble then back-to-back beats.
      do_reset();
      for (int b = 0; b < 3; b++) srcq[0].push_back(beat(0, 0, b, b == 2));
      drive();
      #1 check_eq("t1_idle_tready", 64'(in_tready), 64'h0);
      step();
      check_eq("t1_busy",   64'(busy),       64'h1);
      check_eq("t1_grant",  64'(grant_id),   64'h0);
      check_eq("t1_bubble", 64'(out_tvalid), 64'h0);
      check_eq("t1_tready", 64'(in_tready),  64'h1);
      step();
      check_eq("t1_a0_valid", 64'(out_tvalid), 64'h1);
      check_eq("t1_a0_data",  64'(out_tdata),  64'(bdata(0, 0, 0)));
      check_eq("t1_a0_last",  64'(out_tlast),  64'h0);
      check_eq("t1_a0_keep",  64'(out_tkeep),  64'h1);
      check_eq("t1_a0_user",  64'(out_tuser),  64'h1);
      step();
      check_eq("t1_a1_data",  64'(out_tdata),  64'(bdata(0, 0, 1)));
      check_eq("t1_a1_last",  64'(out_tlast),  64'h0);
      step();
      check_eq("t1_a2_data",  64'(out_tdata),  64'(bdata(0, 0, 2)));
      check_eq("t1_a2_last",  64'(out_tlast),  64'h1);
      check_eq("t1_a2_busy",  64'(busy),       64'h0);
      step();
      check_eq("t1_ret_valid", 64'(out_tvalid), 64'h0);
      check_eq("t1_ret_keep",  64'(out_tkeep),  64'hF);
      check_eq("t1_ret_data",  64'(out_tdata),  64'h0);

      // Three continuous requesters: packet order 0,1,2,0,1,2.
      do_reset();
      for (int s = 0; s < 3; s++)
         for (int p = 0; p < 2; p++)
            for (int b = 0; b < 2; b++) srcq[s].push_back(beat(s, p, b, b == 1));
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < 3; s++)
            for (int b = 0; b < 2; b++) expq.push_back(xfer(s, p, b, b == 1));
      drive();
      run_until("t2", 12, 80);

      // Back-pressure for 5 cycles mid-packet from input 1.
      do_reset();
      for (int b = 0; b < 3; b++) srcq[1].push_back(beat(1, 0, b, b == 2));
      drive();
      step();
      step();
      out_tready = 1'b0;
      drive();
      for (int c = 0; c < 5; c++) begin
         step();
         check_eq("t3_hold_data",   64'(out_tdata),  64'(bdata(1, 0, 0)));
         check_eq("t3_hold_tready", 64'(in_tready),  64'h0);
      end
      out_tready = 1'b1;
      drive();
      for (int b = 0; b < 3; b++) expq.push_back(xfer(1, 0, b, b == 2));
      run_until("t3", 3, 20);

      // Granted input 1 stalls; input 2 must wait for the tlast beat.
      do_reset();
      for (int b = 0; b < 3; b++) srcq[1].push_back(beat(1, 0, b, b == 2));
      for (int b = 0; b < 2; b++) srcq[2].push_back(beat(2, 0, b, b == 1));
      drive();
      step();
      step();
      hold[1] = 1'b1;
      drive();
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("t4_grant",   64'(grant_id),          64'h1);
         check_eq("t4_tready2", 64'(in_tready[2]),      64'h0);
         check_eq("t4_busy",    64'(busy),              64'h1);
      end
      hold[1] = 1'b0;
      drive();
      for (int b = 0; b < 3; b++) expq.push_back(xfer(1, 0, b, b == 2));
      for (int b = 0; b < 2; b++) expq.push_back(xfer(2, 0, b, b == 1));
      run_until("t4", 5, 30);

      // Reset during the second beat, then 0 beats 3 on restart.
      do_reset();
      for (int b = 0; b < 3; b++) srcq[0].push_back(beat(0, 0, b, b == 2));
      drive();
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_valid", 64'(out_tvalid), 64'h0);
      check_eq("t5_rst_keep",  64'(out_tkeep),  64'hF);
      check_eq("t5_rst_busy",  64'(busy),       64'h0);
      check_eq("t5_rst_grant", 64'(grant_id),   64'h0);
      for (int i = 0; i < NUM; i++) srcq[i].delete();
      outq.delete();
      srcq[0].push_back(beat(0, 1, 0, 1'b1));
      srcq[3].push_back(beat(3, 1, 0, 1'b1));
      drive();
      @(negedge clock);
      rst_n = 1'b1;
      expq.push_back(xfer(0, 1, 0, 1'b1));
      expq.push_back(xfer(3, 1, 0, 1'b1));
      run_until("t5", 2, 20);

      // Granted input stalls for TIMEOUT cycles with input 2 waiting.
      do_reset();
      for (int b = 0; b < 2; b++) srcq[1].push_back(beat(1, 0, b, b == 1));
      srcq[2].push_back(beat(2, 0, 0, 1'b1));
      drive();
      step();
      check_eq("t6_grant1", 64'(grant_id), 64'h1);
      hold[1] = 1'b1;
      drive();
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
`ifdef AXIS_RR_ARB_TIMEOUT_EN
         check_eq($sformatf("t6_tout_%0d", k), 64'(timeout_err), 64'(k == TIMEOUT));
         check_eq($sformatf("t6_busy_%0d", k), 64'(busy),        64'(k < TIMEOUT));
`else
         check_eq($sformatf("t6_tout_%0d", k), 64'(timeout_err), 64'h0);
         check_eq($sformatf("t6_busy_%0d", k), 64'(busy),        64'h1);
`endif
      end
      step();
      check_eq("t6_after_tout", 64'(timeout_err), 64'h0);
      check_eq("t6_after_busy", 64'(busy),        64'h1);
`ifdef AXIS_RR_ARB_TIMEOUT_EN
      check_eq("t6_after_grant", 64'(grant_id), 64'h2);
`else
      check_eq("t6_after_grant", 64'(grant_id), 64'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
